// File: rtl/mario_sprite_sequencer.sv
// Big-Mario sprite sequencer: walk/jump frame FSM plus a 2-stage ROM address/colour pipeline.
// Optional macro MARIO_MIRROR_EN enables horizontal mirroring via facing_left.
module mario_sprite_sequencer #(
  parameter int          SPR_W     = 21,
  parameter int          SPR_H     = 41,
  parameter int          ANIM_DIV  = 6,
  parameter logic [23:0] KEY_COLOR = 24'h800080
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_tick,
  input  logic        walking,
  input  logic        airborne,
  input  logic        facing_left,
  input  logic [9:0]  mario_x,
  input  logic [9:0]  mario_y,
  input  logic        pix_req,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  output logic [9:0]  rom_address,
  output logic [2:0]  frame_sel,
  input  logic [23:0] rom_color,
  output logic        pix_valid,
  output logic [23:0] pix_color,
  output logic        pix_opaque
);

  typedef enum logic [2:0] {
    ST_STAND = 3'd0,
    ST_WALK1 = 3'd1,
    ST_WALK2 = 3'd2,
    ST_WALK3 = 3'd3,
    ST_JUMP  = 3'd4
  } anim_state_e;

  localparam logic [5:0] CNT_LAST = 6'(ANIM_DIV - 1);

  anim_state_e state_q;
  logic [5:0]  cnt_q;
  logic [2:0]  frame_sel_q;

  // frame_sel is written together with the state so the ROM mux follows on the cycle after the tick.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= ST_STAND;
      cnt_q       <= '0;
      frame_sel_q <= 3'd0;
    end else if (frame_tick) begin
      if (airborne) begin
        state_q     <= ST_JUMP;
        cnt_q       <= '0;
        frame_sel_q <= 3'd4;
      end else if (!walking) begin
        state_q     <= ST_STAND;
        cnt_q       <= '0;
        frame_sel_q <= 3'd0;
      end else if (state_q == ST_STAND || state_q == ST_JUMP) begin
        state_q     <= ST_WALK1;
        cnt_q       <= '0;
        frame_sel_q <= 3'd1;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        case (state_q)
          ST_WALK1: begin state_q <= ST_WALK2; frame_sel_q <= 3'd2; end
          ST_WALK2: begin state_q <= ST_WALK3; frame_sel_q <= 3'd3; end
          default:  begin state_q <= ST_WALK1; frame_sel_q <= 3'd1; end
        endcase
      end else begin
        cnt_q <= cnt_q + 6'd1;
      end
    end
  end

  logic [10:0] dx_d, dy_d;
  logic        inbox_d;
  logic [9:0]  col_d;
  logic [9:0]  addr_d;

  assign dx_d    = {1'b0, draw_x} - {1'b0, mario_x};
  assign dy_d    = {1'b0, draw_y} - {1'b0, mario_y};
  assign inbox_d = !dx_d[10] && (dx_d < 11'(SPR_W)) && !dy_d[10] && (dy_d < 11'(SPR_H));

`ifdef MARIO_MIRROR_EN
  assign col_d = facing_left ? (10'(SPR_W - 1) - dx_d[9:0]) : dx_d[9:0];
`else
  logic unused_facing_left;
  assign unused_facing_left = facing_left;
  assign col_d = dx_d[9:0];
`endif

  // Inside the box dy*SPR_W+col tops out at 860, so 10-bit arithmetic cannot wrap.
  assign addr_d = inbox_d ? (dy_d[9:0] * 10'(SPR_W) + col_d) : 10'd0;

  logic [9:0]  rom_address_q;
  logic        v1_q, in1_q;
  logic        pix_valid_q, pix_opaque_q;
  logic [23:0] pix_color_q;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rom_address_q <= '0;
      v1_q          <= 1'b0;
      in1_q         <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_color_q   <= '0;
      pix_opaque_q  <= 1'b0;
    end else begin
      rom_address_q <= addr_d;
      v1_q          <= pix_req;
      in1_q         <= inbox_d;
      pix_valid_q   <= v1_q;
      pix_color_q   <= in1_q ? rom_color : 24'd0;
      pix_opaque_q  <= in1_q && (rom_color != KEY_COLOR);
    end
  end

  assign rom_address = rom_address_q;
  assign frame_sel   = frame_sel_q;
  assign pix_valid   = pix_valid_q;
  assign pix_color   = pix_color_q;
  assign pix_opaque  = pix_opaque_q;

endmodule

// File: tb/tb_mario_sprite_sequencer.sv
// Bench for mario_sprite_sequencer: directed scenarios plus randomized pixels/ticks against a reference model.
module tb_mario_sprite_sequencer;

  localparam int          SPR_W    = 21;
  localparam int          SPR_H    = 41;
  localparam int          ANIM_DIV = 6;
  localparam logic [23:0] KEY      = 24'h800080;
`ifdef MARIO_MIRROR_EN
  localparam bit MIRROR = 1'b1;
`else
  localparam bit MIRROR = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n, frame_tick, walking, airborne, facing_left, pix_req;
  logic [9:0]  mario_x, mario_y, draw_x, draw_y;
  logic [9:0]  rom_address;
  logic [2:0]  frame_sel;
  logic [23:0] rom_color;
  logic        pix_valid, pix_opaque;
  logic [23:0] pix_color;
  logic        force_en;
  logic [23:0] force_color;

  int tests = 0;
  int fails = 0;

  int m_frame = 0;
  int m_walk_ticks = 0;

  always #5 Clk = ~Clk;

  // Fake ROM: encodes frame and address so a wrong frame or address shows up in the colour.
  function automatic logic [23:0] rom_fn(input logic [2:0] fs, input logic [9:0] a);
    return {fs, 1'b1, 10'h000, a};
  endfunction

  assign rom_color = force_en ? force_color : rom_fn(frame_sel, rom_address);

  mario_sprite_sequencer dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .walking(walking),
    .airborne(airborne), .facing_left(facing_left), .mario_x(mario_x), .mario_y(mario_y),
    .pix_req(pix_req), .draw_x(draw_x), .draw_y(draw_y), .rom_address(rom_address),
    .frame_sel(frame_sel), .rom_color(rom_color), .pix_valid(pix_valid),
    .pix_color(pix_color), .pix_opaque(pix_opaque)
  );

  // Returns -1 outside the sprite box, otherwise the ROM index.
  function automatic int ref_addr(input int mx, input int my, input int x, input int y, input bit fl);
    int dx, dy, col;
    dx = x - mx;
    dy = y - my;
    if (dx < 0 || dx >= SPR_W || dy < 0 || dy >= SPR_H) return -1;
    col = (MIRROR && fl) ? (SPR_W - 1 - dx) : dx;
    return dy * SPR_W + col;
  endfunction

  // Walk frame derived from the number of walking ticks since entering the walk cycle.
  task automatic model_tick(input bit w, input bit a);
    if (a) m_frame = 4;
    else if (!w) m_frame = 0;
    else if (m_frame == 0 || m_frame == 4) begin
      m_frame = 1;
      m_walk_ticks = 0;
    end else begin
      m_walk_ticks++;
      m_frame = 1 + (m_walk_ticks / ANIM_DIV) % 3;
    end
  endtask

  task automatic step();
    @(negedge Clk);
  endtask

  task automatic do_tick(input bit w, input bit a);
    walking = w;
    airborne = a;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    model_tick(w, a);
  endtask

  task automatic send_pixel(input int mx, input int my, input int x, input int y, input bit fl,
                            output logic [9:0] addr, output logic v_early, output logic v,
                            output logic [23:0] c, output logic o);
    mario_x = 10'(mx); mario_y = 10'(my);
    draw_x = 10'(x); draw_y = 10'(y);
    facing_left = fl;
    pix_req = 1'b1;
    step();
    pix_req = 1'b0;
    addr = rom_address;
    v_early = pix_valid;
    step();
    v = pix_valid;
    c = pix_color;
    o = pix_opaque;
  endtask

  task automatic test_reset();
    logic [9:0] a; logic ve, v, o; logic [23:0] c;
    Reset_n = 1'b0; pix_req = 1'b1; frame_tick = 1'b1; walking = 1'b1; airborne = 1'b0;
    mario_x = 10'd100; mario_y = 10'd200; draw_x = 10'd105; draw_y = 10'd203;
    repeat (3) step();
    tests++; if (frame_sel !== 3'd0) begin fails++; $display("FAIL reset_frame_sel got=%0d exp=0", frame_sel); end
    tests++; if (pix_valid !== 1'b0) begin fails++; $display("FAIL reset_pix_valid got=%b exp=0", pix_valid); end
    tests++; if (rom_address !== 10'd0) begin fails++; $display("FAIL reset_rom_address got=%0d exp=0", rom_address); end
    tests++; if (pix_color !== 24'd0 || pix_opaque !== 1'b0) begin
      fails++; $display("FAIL reset_pix_out got=%h/%b exp=000000/0", pix_color, pix_opaque); end
    pix_req = 1'b0; frame_tick = 1'b0; Reset_n = 1'b1;
    m_frame = 0;
    step(); step();
    tests++; if (pix_valid !== 1'b0) begin fails++; $display("FAIL reset_idle_valid got=%b exp=0", pix_valid); end
    send_pixel(100, 200, 105, 203, 1'b0, a, ve, v, c, o);
    tests++; if (ve !== 1'b0 || v !== 1'b1) begin
      fails++; $display("FAIL reset_first_latency got=%b,%b exp=0,1", ve, v); end
  endtask

  task automatic test_address_latency();
    logic [9:0] a; logic ve, v, o; logic [23:0] c;
    int exp_a;
    exp_a = MIRROR ? 78 : 68;
    send_pixel(100, 200, 105, 203, 1'b0, a, ve, v, c, o);
    tests++; if (a !== 10'd68) begin fails++; $display("FAIL addr_nomirror got=%0d exp=68", a); end
    tests++; if (v !== 1'b1 || c !== rom_fn(3'(m_frame), 10'd68) || o !== 1'b1) begin
      fails++; $display("FAIL pix_nomirror got=%b/%h/%b exp=1/%h/1", v, c, o, rom_fn(3'(m_frame), 10'd68)); end
    send_pixel(100, 200, 105, 203, 1'b1, a, ve, v, c, o);
    tests++; if (a !== 10'(exp_a)) begin fails++; $display("FAIL addr_facing_left got=%0d exp=%0d", a, exp_a); end
  endtask

  task automatic test_box_edges();
    logic [9:0] a; logic ve, v, o; logic [23:0] c;
    send_pixel(100, 200, 120, 240, 1'b0, a, ve, v, c, o);
    tests++; if (a !== 10'd860 || o !== 1'b1 || c !== rom_fn(3'(m_frame), 10'd860)) begin
      fails++; $display("FAIL edge_corner got=%0d/%b/%h exp=860/1/%h", a, o, c, rom_fn(3'(m_frame), 10'd860)); end
    send_pixel(100, 200, 121, 240, 1'b0, a, ve, v, c, o);
    tests++; if (o !== 1'b0 || c !== 24'd0 || v !== 1'b1) begin
      fails++; $display("FAIL edge_right got=%b/%h/%b exp=0/000000/1", o, c, v); end
    send_pixel(100, 200, 99, 203, 1'b0, a, ve, v, c, o);
    tests++; if (o !== 1'b0 || c !== 24'd0) begin fails++; $display("FAIL edge_left got=%b/%h exp=0/000000", o, c); end
    send_pixel(100, 200, 110, 241, 1'b0, a, ve, v, c, o);
    tests++; if (o !== 1'b0) begin fails++; $display("FAIL edge_bottom got=%b exp=0", o); end
    send_pixel(0, 200, 1023, 203, 1'b0, a, ve, v, c, o);
    tests++; if (o !== 1'b0 || a !== 10'd0) begin fails++; $display("FAIL edge_far got=%b/%0d exp=0/0", o, a); end
    send_pixel(1000, 200, 5, 203, 1'b0, a, ve, v, c, o);
    tests++; if (o !== 1'b0) begin fails++; $display("FAIL edge_neg_dx got=%b exp=0", o); end
  endtask

  task automatic test_transparency();
    logic [9:0] a; logic ve, v, o; logic [23:0] c;
    force_en = 1'b1; force_color = KEY;
    send_pixel(100, 200, 110, 210, 1'b0, a, ve, v, c, o);
    tests++; if (o !== 1'b0 || c !== KEY) begin fails++; $display("FAIL key_transparent got=%b/%h exp=0/%h", o, c, KEY); end
    force_color = 24'hF83800;
    send_pixel(100, 200, 110, 210, 1'b0, a, ve, v, c, o);
    tests++; if (o !== 1'b1 || c !== 24'hF83800) begin fails++; $display("FAIL key_opaque got=%b/%h exp=1/f83800", o, c); end
    force_en = 1'b0;
  endtask

  task automatic test_walk_cycle();
    logic [2:0] held;
    for (int t = 1; t <= 19; t++) begin
      do_tick(1'b1, 1'b0);
      tests++; if (frame_sel !== 3'(m_frame)) begin
        fails++; $display("FAIL walk_tick%0d got=%0d exp=%0d", t, frame_sel, m_frame); end
      if (t == 1 || t == 7 || t == 13 || t == 19) begin
        tests++; if (frame_sel !== ((t == 7) ? 3'd2 : (t == 13) ? 3'd3 : 3'd1)) begin
          fails++; $display("FAIL walk_milestone%0d got=%0d", t, frame_sel); end
      end
      held = frame_sel;
      for (int k = 0; k < 3; k++) begin
        walking = 1'($urandom_range(0, 1));
        airborne = 1'($urandom_range(0, 1));
        step();
      end
      tests++; if (frame_sel !== held) begin fails++; $display("FAIL walk_hold%0d got=%0d exp=%0d", t, frame_sel, held); end
    end
  endtask

  task automatic test_priority();
    do_tick(1'b1, 1'b1);
    tests++; if (frame_sel !== 3'd4) begin fails++; $display("FAIL prio_jump got=%0d exp=4", frame_sel); end
    do_tick(1'b1, 1'b0);
    tests++; if (frame_sel !== 3'd1) begin fails++; $display("FAIL prio_land_walk got=%0d exp=1", frame_sel); end
    do_tick(1'b0, 1'b0);
    tests++; if (frame_sel !== 3'd0) begin fails++; $display("FAIL prio_stand got=%0d exp=0", frame_sel); end
  endtask

  task automatic test_random_anim();
    for (int t = 0; t < 80; t++) begin
      do_tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0));
      tests++; if (frame_sel !== 3'(m_frame)) begin
        fails++; $display("FAIL rand_anim%0d got=%0d exp=%0d", t, frame_sel, m_frame); end
      if ($urandom_range(0, 1) == 1) step();
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 200;
    int exp_a [N];
    bit exp_v [N];
    int mx, my;
    logic [23:0] ec;
    mx = int'($urandom_range(0, 1000));
    my = int'($urandom_range(0, 470));
    for (int i = 0; i < N + 2; i++) begin
      if (i >= 1 && i <= N) begin
        tests++; if (rom_address !== 10'((exp_a[i-1] < 0) ? 0 : exp_a[i-1])) begin
          fails++; $display("FAIL b2b_addr%0d got=%0d exp=%0d", i - 1, rom_address, exp_a[i-1]); end
      end
      if (i >= 2) begin
        ec = (exp_a[i-2] < 0) ? 24'd0 : rom_fn(3'(m_frame), 10'(exp_a[i-2]));
        tests++; if (pix_valid !== exp_v[i-2] || pix_color !== ec || pix_opaque !== (exp_a[i-2] >= 0)) begin
          fails++; $display("FAIL b2b_pix%0d got=%b/%h/%b exp=%b/%h/%b", i - 2, pix_valid, pix_color,
                            pix_opaque, exp_v[i-2], ec, exp_a[i-2] >= 0); end
      end
      if (i < N) begin
        draw_x = 10'(mx + int'($urandom_range(0, SPR_W + 6)) - 3);
        draw_y = 10'(my + int'($urandom_range(0, SPR_H + 6)) - 3);
        mario_x = 10'(mx); mario_y = 10'(my);
        facing_left = 1'($urandom_range(0, 1));
        pix_req = 1'($urandom_range(0, 3) != 0);
        exp_v[i] = pix_req;
        exp_a[i] = ref_addr(mx, my, int'(draw_x), int'(draw_y), facing_left);
      end else begin
        pix_req = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_reset_midpipe();
    do_tick(1'b1, 1'b1);
    mario_x = 10'd100; mario_y = 10'd200; draw_x = 10'd105; draw_y = 10'd203;
    pix_req = 1'b1;
    step();
    Reset_n = 1'b0; pix_req = 1'b0;
    step();
    Reset_n = 1'b1;
    m_frame = 0;
    tests++; if (pix_valid !== 1'b0 || frame_sel !== 3'd0) begin
      fails++; $display("FAIL midreset_now got=%b/%0d exp=0/0", pix_valid, frame_sel); end
    step();
    tests++; if (pix_valid !== 1'b0) begin fails++; $display("FAIL midreset_flush got=%b exp=0", pix_valid); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    force_en = 1'b0; force_color = 24'd0;
    facing_left = 1'b0; walking = 1'b0; airborne = 1'b0;
    test_reset();
    test_address_latency();
    test_box_edges();
    test_transparency();
    test_walk_cycle();
    test_address_latency();
    test_priority();
    test_random_anim();
    test_back_to_back();
    test_reset_midpipe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
